// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields and memory handshake into the
// multicycle controller, datapath strobes/selects and status out of it.
// The controller takes the master modport, the datapath/bench the slave one.
interface multicycle_controller_if #(
  parameter int INST_CNT_W = 16
);
  logic [3:0]            opcode;
  logic [5:0]            func;
  logic                  mem_ready;
  logic                  pc_write;
  logic                  pc_write_cond;
  logic                  i_or_d;
  logic                  mem_read;
  logic                  mem_write;
  logic                  mem_to_reg;
  logic                  ir_write;
  logic                  reg_write;
  logic                  alu_src_a;
  logic [1:0]            pc_source;
  logic [1:0]            reg_dst;
  logic [1:0]            alu_src_b;
  logic [1:0]            alu_op;
  logic [2:0]            state;
  logic                  inst_done;
  logic                  wwd_valid;
  logic                  halted;
  logic                  mem_error;
  logic [INST_CNT_W-1:0] num_inst;

  modport master (
    input  opcode, func, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, alu_src_a, pc_source, reg_dst, alu_src_b,
           alu_op, state, inst_done, wwd_valid, halted, mem_error, num_inst
  );

  modport slave (
    output opcode, func, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg,
           ir_write, reg_write, alu_src_a, pc_source, reg_dst, alu_src_b,
           alu_op, state, inst_done, wwd_valid, halted, mem_error, num_inst
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle CPU control FSM with a retired-instruction
// counter. Define MEM_HANDSHAKE_EN to make IF/MEM wait on mem_ready with a
// MEM_TIMEOUT watchdog; without it IF/MEM are single-cycle and mem_ready is
// ignored.
//
//   state  | meaning
//   IF   0 | instruction fetch, IR/PC written on completion
//   ID   1 | decode, branch target into ALUOut, jumps resolved
//   EX   2 | ALU operation / address calc / branch compare
//   MEM  3 | data load or store
//   WB   4 | register file write-back
//   HALT 5 | absorbing until reset (HLT or memory timeout)
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int INST_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [2:0] {
    stIf = 3'd0, stId = 3'd1, stEx = 3'd2, stMem = 3'd3, stWb = 3'd4, stHalt = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    clsBr, clsIalu, clsLwd, clsSwd, clsJmp, clsJal,
    clsJpr, clsJrl, clsWwd, clsHlt, clsRalu, clsNop
  } instClass_t;

  state_t                state, nextState;
  instClass_t            instClass;
  logic                  instDone;
  logic                  memDone;
  logic                  timeout;
  logic [INST_CNT_W-1:0] numInst;

  // Classify the instruction held in the IR.
  always_comb begin
    instClass = clsNop;
    case (bus.opcode)
      4'd0, 4'd1, 4'd2, 4'd3: instClass = clsBr;
      4'd4, 4'd5, 4'd6:       instClass = clsIalu;
      4'd7:                   instClass = clsLwd;
      4'd8:                   instClass = clsSwd;
      4'd9:                   instClass = clsJmp;
      4'd10:                  instClass = clsJal;
      4'd15: begin
        case (bus.func)
          6'd25:   instClass = clsJpr;
          6'd26:   instClass = clsJrl;
          6'd28:   instClass = clsWwd;
          6'd29:   instClass = clsHlt;
          default: instClass = clsRalu;
        endcase
      end
      default:                instClass = clsNop;
    endcase
  end

`ifdef MEM_HANDSHAKE_EN
  logic [7:0] waitCnt;
  logic       memError;

  // A completing mem_ready always beats the timeout in the same cycle.
  assign memDone = bus.mem_ready;
  assign timeout = !bus.mem_ready && ((state == stIf) || (state == stMem)) &&
                   ((waitCnt + 8'd1) == 8'(MEM_TIMEOUT));

  // Wait counter: restarts on every state change, counts stalled cycles.
  always_ff @(posedge clk) begin
    if (reset)
      waitCnt <= '0;
    else if (nextState != state)
      waitCnt <= '0;
    else if (((state == stIf) || (state == stMem)) && !bus.mem_ready)
      waitCnt <= waitCnt + 8'd1;
  end

  // Sticky memory error flag.
  always_ff @(posedge clk) begin
    if (reset)
      memError <= 1'b0;
    else if (timeout)
      memError <= 1'b1;
  end

  assign bus.mem_error = memError;
`else
  logic unusedMemReady;

  assign memDone        = 1'b1;
  assign timeout        = 1'b0;
  assign unusedMemReady = bus.mem_ready;
  assign bus.mem_error  = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset)
      state <= stIf;
    else
      state <= nextState;
  end

  // Next state and per-state outputs; everything stays 0 while reset is high.
  always_comb begin
    nextState         = state;
    instDone          = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.pc_source     = 2'd0;
    bus.reg_dst       = 2'd0;
    bus.alu_src_b     = 2'd0;
    bus.alu_op        = 2'd0;
    bus.wwd_valid     = 1'b0;
    bus.halted        = 1'b0;
    if (!reset) begin
      case (state)
        stIf: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'd1;
          if (memDone) begin
            bus.ir_write = 1'b1;
            bus.pc_write = 1'b1;
            nextState    = stId;
          end else if (timeout) begin
            nextState = stHalt;
          end
        end
        stId: begin
          bus.alu_src_b = 2'd2;
          case (instClass)
            clsJmp: begin
              bus.pc_write  = 1'b1;
              bus.pc_source = 2'd2;
            end
            clsJpr: begin
              bus.pc_write  = 1'b1;
              bus.pc_source = 2'd3;
            end
            clsJal, clsJrl: begin
              bus.reg_write = 1'b1;
              bus.reg_dst   = 2'd2;
            end
            clsWwd:  bus.wwd_valid = 1'b1;
            default: ;
          endcase
          case (instClass)
            clsRalu, clsIalu, clsLwd, clsSwd, clsBr: nextState = stEx;
            clsHlt:  nextState = stHalt;
            default: begin
              instDone  = 1'b1;
              nextState = stIf;
            end
          endcase
        end
        stEx: begin
          bus.alu_src_a = 1'b1;
          nextState     = stIf;
          case (instClass)
            clsRalu: begin
              bus.alu_op = 2'd2;
              nextState  = stWb;
            end
            clsIalu: begin
              bus.alu_src_b = 2'd2;
              bus.alu_op    = 2'd3;
              nextState     = stWb;
            end
            clsLwd, clsSwd: begin
              bus.alu_src_b = 2'd2;
              nextState     = stMem;
            end
            clsBr: begin
              bus.alu_op        = 2'd1;
              bus.pc_write_cond = 1'b1;
              bus.pc_source     = 2'd1;
              instDone          = 1'b1;
            end
            default: ;
          endcase
        end
        stMem: begin
          bus.i_or_d    = 1'b1;
          bus.mem_read  = (instClass == clsLwd);
          bus.mem_write = (instClass == clsSwd);
          if (memDone) begin
            if (instClass == clsLwd) begin
              nextState = stWb;
            end else begin
              instDone  = 1'b1;
              nextState = stIf;
            end
          end else if (timeout) begin
            nextState = stHalt;
          end
        end
        stWb: begin
          bus.reg_write  = 1'b1;
          bus.reg_dst    = (instClass == clsRalu) ? 2'd1 : 2'd0;
          bus.mem_to_reg = (instClass == clsLwd);
          instDone       = 1'b1;
          nextState      = stIf;
        end
        stHalt: bus.halted = 1'b1;
        default: nextState = stIf;
      endcase
    end
  end

  // Retired-instruction counter, wraps silently.
  always_ff @(posedge clk) begin
    if (reset)
      numInst <= '0;
    else if (instDone)
      numInst <= numInst + INST_CNT_W'(1);
  end

  assign bus.state     = state;
  assign bus.inst_done = instDone;
  assign bus.num_inst  = numInst;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: the maximum number of consecutive mem_ready-low cycles allowed in any memory-wait state (legal range 1..255).
REQ-002 Parameter INST_CNT_W, default 16: the width of the retired-instruction counter.
REQ-003 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: reset, synchronous and active-high.
REQ-005 Port opcode, input, 4: bits [15:12] of the instruction register, valid from the ID state onward.
REQ-006 Port func, input, 6: bits [5:0] of the instruction register.
REQ-007 Port mem_ready, input, 1: memory completion for the current access.
REQ-008 Ports pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write and alu_src_a, output, 1 each: datapath strobes and mux selects.
REQ-009 Ports pc_source, reg_dst, alu_src_b and alu_op, output, 2 each: mux selects; reg_dst encodes 0 rt, 1 rd, 2 $2.
REQ-010 Port state, output, 3: current state, encoded IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
REQ-011 Ports inst_done, wwd_valid and halted, output, 1 each; mem_error, output, 1; num_inst, output, INST_CNT_W.

Function
REQ-012 Instruction classes SHALL be:
- opcode 0-3: BR
- 4-6: IALU
- 7: LWD
- 8: SWD
- 9: JMP
- 10: JAL
- opcode 15 with func 25: JPR
- func 26: JRL
- func 28: WWD
- func 29: HLT
- any other func with opcode 15: RALU
- any other opcode: NOP.
REQ-013 State sequences SHALL be:
- RALU and IALU: IF-ID-EX-WB
- LWD: IF-ID-EX-MEM-WB
- SWD: IF-ID-EX-MEM
- BR: IF-ID-EX
- JMP, JAL, JPR, JRL, WWD and NOP: IF-ID
- HLT: IF-ID-HALT.
After the final state of each sequence the next state SHALL be IF.
REQ-014 IF SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0 and pc_source=0; ir_write and pc_write SHALL be 1 only in the completing cycle.
REQ-015 ID SHALL drive alu_src_a=0, alu_src_b=2 and alu_op=0 (branch target into ALUOut).
- JMP: pc_write=1, pc_source=2.
- JPR: pc_write=1, pc_source=3.
- JAL: additionally reg_write=1, reg_dst=2, mem_to_reg=0.
- JRL: additionally reg_write=1, reg_dst=2, mem_to_reg=0.
REQ-016 EX SHALL drive alu_src_a=1.
- RALU: alu_src_b=0, alu_op=2.
- IALU: alu_src_b=2, alu_op=3.
- LWD and SWD: alu_src_b=2, alu_op=0.
- BR: alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1.
REQ-017 MEM SHALL drive i_or_d=1, with mem_read=1 for LWD and mem_write=1 for SWD.
REQ-018 WB SHALL drive reg_write=1, with reg_dst=1 for RALU and 0 otherwise, and mem_to_reg=1 only for LWD.
REQ-019 Every output not named for a state SHALL be 0 in that state.
REQ-020 inst_done SHALL pulse for exactly one cycle in the final state of each sequence (HALT excluded), and num_inst SHALL increment in that same cycle.
REQ-021 num_inst SHALL wrap from all-ones to 0 without any flag.
REQ-022 wwd_valid SHALL be 1 during the ID state of a WWD instruction.
REQ-023 HALT SHALL be absorbing until reset.
- halted=1 in HALT.
- All strobes 0 in HALT.
- inst_done is not asserted for HLT.
REQ-024 A wait counter SHALL clear on entry to IF and to MEM, and SHALL increment on each mem_ready-low cycle in that state.
REQ-025 When the wait counter reaches MEM_TIMEOUT with mem_ready low, the next state SHALL be HALT and mem_error SHALL be set; mem_error is sticky until reset.
REQ-026 When mem_ready rises in the same cycle the counter reaches MEM_TIMEOUT, completion SHALL win and no error SHALL be raised.

Reset
REQ-027 While reset is high at a clock edge:
- state SHALL be IF.
- num_inst, the wait counter, mem_error and halted SHALL be 0.
REQ-028 All strobes SHALL be 0 during the reset cycle, and the first IF SHALL begin on the cycle after reset falls.
REQ-029 Reset asserted in any state, including mid-MEM and HALT, SHALL take effect at that edge; no write strobe SHALL be asserted during the reset cycle.

Configuration
REQ-030 Macro MEM_HANDSHAKE_EN SHALL control memory handshaking.
REQ-031 With MEM_HANDSHAKE_EN defined:
- IF and MEM SHALL hold until mem_ready=1; the completing cycle is the mem_ready=1 cycle.
- The timeout behaviour of REQ-024..026 SHALL apply.
REQ-032 With MEM_HANDSHAKE_EN undefined:
- IF and MEM SHALL last exactly one cycle, and each of those cycles is the completing cycle.
- mem_ready SHALL be ignored.
- mem_error SHALL be constant 0.

Verification
REQ-033 RALU (opcode 15, func 0) with mem_ready held 1 -> state 0,1,2,4,0; inst_done on WB; num_inst 0->1.
REQ-034 LWD (opcode 7) with MEM_HANDSHAKE_EN and mem_ready low for 3 MEM cycles -> MEM lasts 4 cycles; mem_to_reg=1 and reg_dst=0 in WB.
REQ-035 MEM_TIMEOUT=4, mem_ready stuck 0 in IF -> HALT after 4 wait cycles; mem_error=1 and halted=1; reset then returns state to 0.
REQ-036 BR (opcode 0) -> pc_write_cond=1 and pc_source=1 in EX; inst_done in EX; total of 3 cycles.
REQ-037 JAL (opcode 10) then HLT (opcode 15, func 29) -> JAL gives reg_write=1 and reg_dst=2 in ID; HLT reaches HALT with num_inst unchanged by HLT.
REQ-038 INST_CNT_W=2, five NOP instructions -> num_inst sequence 1,2,3,0,1.
